id_ex_forward_reg: RTL
======================

ID_EX_FORWARD_REG -- requirements
Module: id_ex_forward_reg

Interface
REQ-001 Clk  in  1  single clock; all state updates on its rising edge.
REQ-002 Reset  in  1  asynchronous, active-high reset.
REQ-003 Stall  in  1  1 = hold all registered outputs this edge.
REQ-004 Flush  in  1  1 = load a bubble this edge (branch taken).
REQ-005 ID_Valid  in  1  decode-stage instruction valid.
REQ-006 PA, PB, PD  in  32 each  register-file read ports A/B/D.
REQ-007 RA, RB, RD  in  4 each  register numbers driving PA/PB/PD.
REQ-008 ID_Use  in  3  operand-used flags: bit0 A, bit1 B, bit2 D.
REQ-009 ID_RW, ID_LE, ID_Ctrl  in  4/1/16  destination reg, dest write enable, opaque control word.
REQ-010 EX_RW, EX_LE, EX_Load, EX_Result  in  4/1/1/32  EX-stage dest, write enable, is-load, ALU result.
REQ-011 MEM_RW, MEM_LE, MEM_Result  in  4/1/32  MEM-stage dest, write enable, data.
REQ-012 WB_RW, WB_LE, WB_PW  in  4/1/32  WB-stage dest, write enable, write data (same value presented to the register file PW).
REQ-013 Q_A, Q_B, Q_D  out  32 each  registered forwarded operands.
REQ-014 Q_RW, Q_LE, Q_Ctrl, Q_Valid  out  4/1/16/1  registered dest, write enable, control, valid.
REQ-015 Load_Use  out  1  combinational load-use hazard; upstream stalls PC and IF/ID on it.
REQ-016 Bubble_Cnt  out  8  registered count of load-use bubbles.

Function
REQ-017 Per operand X in {A,B,D}, forwarded value SHALL be chosen in priority: source reg 15 -> raw PX; EX_LE & ~EX_Load & EX_RW==RX -> EX_Result; MEM_LE & MEM_RW==RX -> MEM_Result; WB_LE & WB_RW==RX -> WB_PW; else raw PX.
REQ-018 Register 15 (PC) SHALL never be forwarded; PX passes through unchanged.
REQ-019 Load_Use SHALL = ID_Valid & EX_LE & EX_Load & OR over X of (ID_Use[X] & RX==EX_RW & RX!=15).
REQ-020 Edge priority SHALL be: Flush > Stall > Load_Use > normal load.
REQ-021 Flush edge: Q_Valid=0, Q_LE=0, Q_Ctrl=0, Q_RW=0, Q_A/B/D=0.
REQ-022 Stall edge (no Flush): all Q_* and Bubble_Cnt hold.
REQ-023 Load_Use edge (no Flush/Stall): bubble as REQ-021; Bubble_Cnt increments, saturating at 255.
REQ-024 Normal edge: Q_A/B/D = forwarded values, Q_RW=ID_RW, Q_Ctrl=ID_Ctrl, Q_Valid=ID_Valid, Q_LE=ID_LE&ID_Valid.
REQ-025 Latency SHALL be exactly one Clk edge from ID inputs to Q outputs.
REQ-026 ID_Valid=0 SHALL suppress Load_Use and produce a bubble on a normal edge.
REQ-027 Forwarding on EX and MEM matching same register: EX wins (REQ-017); Load_Use overrides whenever EX_Load.

Reset
REQ-028 Reset=1 SHALL immediately force all Q_* and Bubble_Cnt to 0 regardless of Clk, Stall or Flush.
REQ-029 Reset deassertion mid-operation SHALL resume normal behaviour at the next rising edge; no state survives.

Structure
REQ-030 Shared package: DATA_W=32, REG_W=4, CTRL_W=16, PC_REG=4'd15, forward-source enum {FWD_RF, FWD_EX, FWD_MEM, FWD_WB}.
REQ-031 One sub-module fwd_select (per-operand priority mux, REQ-017/018), instantiated three times.

Verification
REQ-032 RA=3, PA=5, EX_LE=1, EX_RW=3, EX_Result=100, MEM_RW=3, MEM_Result=200 -> after edge Q_A=100.
REQ-033 RB=15, PB=32, EX/MEM/WB all writing reg 15 -> Q_B=32, Load_Use=0.
REQ-034 EX_Load=1, EX_LE=1, EX_RW=7, RD=7, ID_Use=3'b100, ID_Valid=1 -> Load_Use=1; after edge Q_Valid=0, Q_LE=0, Bubble_Cnt=1; same with ID_Use=3'b011 -> Load_Use=0.
REQ-035 Stall=1 and Flush=1 same edge with Q_Valid=1 -> Q_Valid=0; Stall alone -> Q_* unchanged for 3 edges.
REQ-036 Hold load-use condition 300 edges -> Bubble_Cnt saturates at 255; assert Reset between edges -> all Q_* and Bubble_Cnt 0 before next edge.

Source files
------------

// File: rtl/id_ex_forward_reg_pkg.sv
// Shared types and helpers for the ID/EX pipeline register with operand forwarding.
// Widths, the non-forwardable PC register number and the forward-source encoding live here.
package id_ex_forward_reg_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 4;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 8;

    localparam logic [REG_W-1:0] PC_REG = 4'd15;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_src_e;

    // Everything the ID/EX register carries into the execute stage.
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] d;
        logic [REG_W-1:0]  rw;
        logic              le;
        logic [CTRL_W-1:0] ctrl;
        logic              valid;
    } id_ex_t;

    localparam id_ex_t ID_EX_BUBBLE = '0;

    // A later stage supplies a register when it will write it and the numbers agree.
    function automatic logic reg_hit(input logic le, input logic [REG_W-1:0] rw,
                                     input logic [REG_W-1:0] rx);
        return le & (rw == rx);
    endfunction

    // Event counter that sticks at its maximum instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/id_ex_forward_reg_fwd_select.sv
// Per-operand forwarding mux: picks the youngest in-flight producer of a source register,
// and flags when that producer is a load still in EX (data not yet available).
module fwd_select
    import id_ex_forward_reg_pkg::*;
(
    input  logic [REG_W-1:0]  rx,
    input  logic [DATA_W-1:0] px,
    input  logic              use_op,
    input  logic              ex_le,
    input  logic              ex_load,
    input  logic [REG_W-1:0]  ex_rw,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              mem_le,
    input  logic [REG_W-1:0]  mem_rw,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_le,
    input  logic [REG_W-1:0]  wb_rw,
    input  logic [DATA_W-1:0] wb_pw,
    output logic [DATA_W-1:0] fwd_val,
    output logic              lu_hit
);

    fwd_src_e src_s;

    // Source priority: PC is never forwarded, then EX (non-load), MEM, WB, else register file.
    always_comb begin
        src_s = FWD_RF;
        if (rx == PC_REG) begin
            src_s = FWD_RF;
        end else if (reg_hit(ex_le & ~ex_load, ex_rw, rx)) begin
            src_s = FWD_EX;
        end else if (reg_hit(mem_le, mem_rw, rx)) begin
            src_s = FWD_MEM;
        end else if (reg_hit(wb_le, wb_rw, rx)) begin
            src_s = FWD_WB;
        end else begin
            src_s = FWD_RF;
        end
    end

    // Data steering for the chosen source.
    always_comb begin
        fwd_val = px;
        case (src_s)
            FWD_EX:  fwd_val = ex_result;
            FWD_MEM: fwd_val = mem_result;
            FWD_WB:  fwd_val = wb_pw;
            default: fwd_val = px;
        endcase
    end

    // Load in EX targeting a used, non-PC source: the value cannot be forwarded yet.
    always_comb begin
        lu_hit = 1'b0;
        if (use_op && (rx != PC_REG)) begin
            lu_hit = reg_hit(ex_le & ex_load, ex_rw, rx);
        end else begin
            lu_hit = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_forward_reg.sv
// ID/EX pipeline register: forwards operands from EX/MEM/WB, detects load-use hazards,
// inserts bubbles on flush or hazard, and counts hazard bubbles.
module id_ex_forward_reg
    import id_ex_forward_reg_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              ID_Valid,
    input  logic [DATA_W-1:0] PA,
    input  logic [DATA_W-1:0] PB,
    input  logic [DATA_W-1:0] PD,
    input  logic [REG_W-1:0]  RA,
    input  logic [REG_W-1:0]  RB,
    input  logic [REG_W-1:0]  RD,
    input  logic [2:0]        ID_Use,
    input  logic [REG_W-1:0]  ID_RW,
    input  logic              ID_LE,
    input  logic [CTRL_W-1:0] ID_Ctrl,
    input  logic [REG_W-1:0]  EX_RW,
    input  logic              EX_LE,
    input  logic              EX_Load,
    input  logic [DATA_W-1:0] EX_Result,
    input  logic [REG_W-1:0]  MEM_RW,
    input  logic              MEM_LE,
    input  logic [DATA_W-1:0] MEM_Result,
    input  logic [REG_W-1:0]  WB_RW,
    input  logic              WB_LE,
    input  logic [DATA_W-1:0] WB_PW,
    output logic [DATA_W-1:0] Q_A,
    output logic [DATA_W-1:0] Q_B,
    output logic [DATA_W-1:0] Q_D,
    output logic [REG_W-1:0]  Q_RW,
    output logic              Q_LE,
    output logic [CTRL_W-1:0] Q_Ctrl,
    output logic              Q_Valid,
    output logic              Load_Use,
    output logic [CNT_W-1:0]  Bubble_Cnt
);

    logic [DATA_W-1:0] fwd_a_s;
    logic [DATA_W-1:0] fwd_b_s;
    logic [DATA_W-1:0] fwd_d_s;
    logic [2:0]        lu_hit_s;
    logic              load_use_s;

    id_ex_t            stage_r;
    id_ex_t            stage_nxt_s;
    logic [CNT_W-1:0]  bubble_cnt_r;
    logic [CNT_W-1:0]  bubble_cnt_nxt_s;

    fwd_select u_fwd_a (
        .rx(RA), .px(PA), .use_op(ID_Use[0]),
        .ex_le(EX_LE), .ex_load(EX_Load), .ex_rw(EX_RW), .ex_result(EX_Result),
        .mem_le(MEM_LE), .mem_rw(MEM_RW), .mem_result(MEM_Result),
        .wb_le(WB_LE), .wb_rw(WB_RW), .wb_pw(WB_PW),
        .fwd_val(fwd_a_s), .lu_hit(lu_hit_s[0])
    );

    fwd_select u_fwd_b (
        .rx(RB), .px(PB), .use_op(ID_Use[1]),
        .ex_le(EX_LE), .ex_load(EX_Load), .ex_rw(EX_RW), .ex_result(EX_Result),
        .mem_le(MEM_LE), .mem_rw(MEM_RW), .mem_result(MEM_Result),
        .wb_le(WB_LE), .wb_rw(WB_RW), .wb_pw(WB_PW),
        .fwd_val(fwd_b_s), .lu_hit(lu_hit_s[1])
    );

    fwd_select u_fwd_d (
        .rx(RD), .px(PD), .use_op(ID_Use[2]),
        .ex_le(EX_LE), .ex_load(EX_Load), .ex_rw(EX_RW), .ex_result(EX_Result),
        .mem_le(MEM_LE), .mem_rw(MEM_RW), .mem_result(MEM_Result),
        .wb_le(WB_LE), .wb_rw(WB_RW), .wb_pw(WB_PW),
        .fwd_val(fwd_d_s), .lu_hit(lu_hit_s[2])
    );

    // Hazard is combinational so upstream can freeze PC and IF/ID in the same cycle.
    assign load_use_s = ID_Valid & (|lu_hit_s);

    // Next-state selection with priority Flush > Stall > load-use bubble > normal load.
    always_comb begin
        stage_nxt_s      = stage_r;
        bubble_cnt_nxt_s = bubble_cnt_r;
        if (Flush) begin
            stage_nxt_s = ID_EX_BUBBLE;
        end else if (Stall) begin
            stage_nxt_s      = stage_r;
            bubble_cnt_nxt_s = bubble_cnt_r;
        end else if (load_use_s) begin
            stage_nxt_s      = ID_EX_BUBBLE;
            bubble_cnt_nxt_s = sat_inc(bubble_cnt_r);
        end else begin
            stage_nxt_s.a     = fwd_a_s;
            stage_nxt_s.b     = fwd_b_s;
            stage_nxt_s.d     = fwd_d_s;
            stage_nxt_s.rw    = ID_RW;
            stage_nxt_s.le    = ID_LE & ID_Valid;
            stage_nxt_s.ctrl  = ID_Ctrl;
            stage_nxt_s.valid = ID_Valid;
        end
    end

    // Pipeline state and bubble counter; Reset clears both immediately.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stage_r      <= ID_EX_BUBBLE;
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else begin
            stage_r      <= stage_nxt_s;
            bubble_cnt_r <= bubble_cnt_nxt_s;
        end
    end

    assign Q_A        = stage_r.a;
    assign Q_B        = stage_r.b;
    assign Q_D        = stage_r.d;
    assign Q_RW       = stage_r.rw;
    assign Q_LE       = stage_r.le;
    assign Q_Ctrl     = stage_r.ctrl;
    assign Q_Valid    = stage_r.valid;
    assign Load_Use   = load_use_s;
    assign Bubble_Cnt = bubble_cnt_r;

endmodule
